// File: rtl/fetch_stall_stage.sv
// fetch_stall_stage: PC register plus IF/ID pipeline register for the fetch stage.
// The hazard unit's stall enables hold the PC and IF/ID independently. A branch
// redirect from a later stage overrides both stalls. Saturating stall/flush counters
// and a debug FSM report what the stage has been doing.
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   pcEnable, ifEnable          hazard-unit advance enables for PC and IF/ID
//   branchTaken, branchTarget   redirect request and its target address
//   imemAddr / imemData         instruction-memory address (= pc) and read data
//   ifidInstr, ifidPcPlus4,     registered instruction, its PC+PC_STEP, and valid flag
//   ifidValid
//   fetchState                  debug FSM state: 0 BOOT, 1 RUN, 2 STALL, 3 REDIRECT
//   stallCount, flushCount      saturating performance counters
module fetch_stall_stage #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pcEnable,
  input  logic               ifEnable,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [ADDR_W-1:0]  ifidPcPlus4,
  output logic               ifidValid,
  output logic [1:0]         fetchState,
  output logic [15:0]        stallCount,
  output logic [15:0]        flushCount
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] BOOT     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STALL    = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcNext;
  logic [1:0]        nextState;
  logic              stallEdge;

  // Sequential PC; modular add gives the wrap from the top of the address space.
  assign pcNext    = pc + ADDR_W'(PC_STEP);
  assign imemAddr  = pc;
  assign stallEdge = !branchTaken && !pcEnable;

  // Debug FSM next-state; a redirect wins from any state.
  always_comb begin
    nextState = fetchState;
    if (branchTaken) begin
      nextState = REDIRECT;
    end else begin
      case (fetchState)
        BOOT:     if (pcEnable) nextState = RUN;
        RUN:      if (!pcEnable) nextState = STALL;
        STALL:    if (pcEnable) nextState = RUN;
        REDIRECT: nextState = pcEnable ? RUN : STALL;
        default:  nextState = BOOT;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchState <= BOOT;
    end else begin
      fetchState <= nextState;
    end
  end

  // PC register: redirect, else advance when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (branchTaken) begin
      pc <= branchTarget;
    end else if (pcEnable) begin
      pc <= pcNext;
    end
  end

  // IF/ID register: redirect inserts a bubble, else load when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifidInstr   <= '0;
      ifidPcPlus4 <= '0;
      ifidValid   <= 1'b0;
    end else if (branchTaken) begin
      ifidInstr   <= '0;
      ifidPcPlus4 <= '0;
      ifidValid   <= 1'b0;
    end else if (ifEnable) begin
      ifidInstr   <= imemData;
      ifidPcPlus4 <= pcNext;
      ifidValid   <= 1'b1;
    end
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stallEdge && (stallCount != {CNT_W{1'b1}})) begin
        stallCount <= stallCount + CNT_W'(1);
      end
      if (branchTaken && (flushCount != {CNT_W{1'b1}})) begin
        flushCount <= flushCount + CNT_W'(1);
      end
    end
  end

endmodule
